// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong score path: BCD score type,
// 3x5 digit font and the font cell geometry in font units.
package pong_pkg;

  typedef logic [7:0] score_t;

  localparam int DIG_W_U = 3;
  localparam int DIG_H_U = 5;
  localparam int GAP_U   = 1;
  localparam int CELL_U  = DIG_W_U + GAP_U;

  // Row-major glyphs, bit 14 is the top-left pixel.
  localparam logic [14:0] FONT_3X5 [0:9] = '{
    15'b111_101_101_101_111,
    15'b010_110_010_010_111,
    15'b111_001_111_100_111,
    15'b111_001_111_001_111,
    15'b101_101_111_001_001,
    15'b111_100_111_001_111,
    15'b111_100_111_101_111,
    15'b111_001_001_001_001,
    15'b111_101_111_101_111,
    15'b111_101_111_001_111
  };

  function automatic logic font_bit(input logic [3:0] d, input logic [1:0] col,
                                    input logic [2:0] row);
    logic [14:0] g;
    logic [3:0]  idx;
    g   = '0;
    idx = 4'd14 - ({1'b0, row} * 4'd3 + {2'b00, col});
    if (d <= 4'd9) g = FONT_3X5[d];
    return (row <= 3'd4 && col <= 2'd2) ? g[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/bcd_inc.sv
// Two-digit BCD incrementer; 99 stays at 99.
module bcd_inc
  import pong_pkg::*;
(
  input  logic [7:0] val_i,
  output logic [7:0] inc_o
);

  always_comb begin
    inc_o = val_i;
    if (val_i == 8'h99)          inc_o = 8'h99;
    else if (val_i[3:0] >= 4'd9) inc_o = {val_i[7:4] + 4'd1, 4'd0};
    else                         inc_o = {val_i[7:4], val_i[3:0] + 4'd1};
  end

endmodule

// File: rtl/pong_score.sv
// Pong score keeper and 2-cycle score pixel renderer.
// Define PONG_SCORE_BLINK_EN to blink the winner's digits at game over.
module pong_score
  import pong_pkg::*;
#(
  parameter int          CORDW      = 10,
  parameter logic [7:0]  WIN_SCORE  = 8'h11,
  parameter int          SCALE_LOG2 = 2,
  parameter int          P1_X       = 256,
  parameter int          P2_X       = 352,
  parameter int          DIG_Y      = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             frame,
  input  logic             clear,
  input  logic             miss_l,
  input  logic             miss_r,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  output logic             score_draw,
  output logic [7:0]       score_p1,
  output logic [7:0]       score_p2,
  output logic             game_over,
  output logic             winner
);

  typedef logic [CORDW:0] cord_t;

  localparam int    S     = 1 << SCALE_LOG2;
  localparam cord_t CW_W  = cord_t'(DIG_W_U * S);
  localparam cord_t CH_W  = cord_t'(DIG_H_U * S);
  localparam cord_t DY    = cord_t'(DIG_Y);
  localparam cord_t [3:0] CX = {cord_t'(P2_X + CELL_U * S), cord_t'(P2_X),
                                cord_t'(P1_X + CELL_U * S), cord_t'(P1_X)};

  // ---------------- score state ----------------
  score_t p1_q, p1_d, p2_q, p2_d, p1_inc, p2_inc;
  logic   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic   go_q, go_d, win_q, win_d;

  bcd_inc u_inc_p1 (.val_i(p1_q), .inc_o(p1_inc));
  bcd_inc u_inc_p2 (.val_i(p2_q), .inc_o(p2_inc));

  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    go_d     = go_q;
    win_d    = win_q;
    if (clear) begin
      p1_d     = '0;
      p2_d     = '0;
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
      go_d     = 1'b0;
      win_d    = 1'b0;
    end else if (go_q) begin
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end else if (frame) begin
      if (pend_r_q) p1_d = p1_inc;
      if (pend_l_q) p2_d = p2_inc;
      // a miss on the frame cycle itself counts toward the next frame
      pend_l_d = miss_l;
      pend_r_d = miss_r;
      if (p1_d == WIN_SCORE) begin
        go_d  = 1'b1;
        win_d = 1'b0;
      end else if (p2_d == WIN_SCORE) begin
        go_d  = 1'b1;
        win_d = 1'b1;
      end
    end else begin
      pend_l_d = pend_l_q | miss_l;
      pend_r_d = pend_r_q | miss_r;
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      p1_q     <= '0;
      p2_q     <= '0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      go_q     <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      go_q     <= go_d;
      win_q    <= win_d;
    end
  end

  // ---------------- render stage 1 ----------------
  cord_t       sx_w, sy_w, dy, dx;
  cord_t [3:0] dxc;
  logic  [3:0] xin;
  logic        y_in;
  logic        hit_q, hit_d, de_q;
  logic  [1:0] cell_q, cell_d, col_q, col_d;
  logic  [2:0] row_q, row_d;

  assign sx_w = {1'b0, sx};
  assign sy_w = {1'b0, sy};
  assign y_in = (sy_w >= DY) && (sy_w < DY + CH_W);

  for (genvar c = 0; c < 4; c++) begin : g_cell
    assign xin[c] = (sx_w >= CX[c]) && (sx_w < CX[c] + CW_W);
    assign dxc[c] = sx_w - CX[c];
  end

  always_comb begin
    cell_d = 2'd0;
    dx     = '0;
    dy     = '0;
    if (xin[0])      begin cell_d = 2'd0; dx = dxc[0]; end
    else if (xin[1]) begin cell_d = 2'd1; dx = dxc[1]; end
    else if (xin[2]) begin cell_d = 2'd2; dx = dxc[2]; end
    else if (xin[3]) begin cell_d = 2'd3; dx = dxc[3]; end
    if (y_in) dy = sy_w - DY;
    hit_d = y_in & (|xin);
    col_d = 2'(dx >> SCALE_LOG2);
    row_d = 3'(dy >> SCALE_LOG2);
  end

  // ---------------- render stage 2 ----------------
  logic [3:0] digit;
  logic       blank, hide, draw_q, draw_d;

`ifdef PONG_SCORE_BLINK_EN
  logic [4:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (clear)      blink_d = '0;
    else if (frame) blink_d = blink_q + 5'd1;
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_d;
  end

  // cell_q[1] selects the player: 0 = P1 cells, 1 = P2 cells
  assign hide = go_q & (cell_q[1] == win_q) & blink_q[4];
`else
  assign hide = 1'b0;
`endif

  always_comb begin
    case (cell_q)
      2'd0:    digit = p1_q[7:4];
      2'd1:    digit = p1_q[3:0];
      2'd2:    digit = p2_q[7:4];
      default: digit = p2_q[3:0];
    endcase
    blank  = ~cell_q[0] & (digit == 4'd0);
    draw_d = de_q & hit_q & font_bit(digit, col_q, row_q) & ~blank & ~hide;
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      de_q   <= 1'b0;
      hit_q  <= 1'b0;
      cell_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      draw_q <= 1'b0;
    end else begin
      de_q   <= de;
      hit_q  <= hit_d;
      cell_q <= cell_d;
      col_q  <= col_d;
      row_q  <= row_d;
      draw_q <= draw_d;
    end
  end

  assign score_draw = draw_q;
  assign score_p1   = p1_q;
  assign score_p2   = p2_q;
  assign game_over  = go_q;
  assign winner     = win_q;

endmodule

// File: doc/pong_score.md
# pong_score

Score keeper and on-screen score renderer for the Pong display path. Sits beside the ball/paddle logic in the `clk_pix` domain. Consumes per-frame miss events and the raster position from `simple_display_timings_480p`. Maintains two BCD scores, detects game over, and produces a pipelined `score_draw` pixel mask that the top ORs into the VGA output register.

## Interface
- `CORDW`, 10: screen coordinate width.
- `WIN_SCORE`, 8'h11: BCD score that ends the game; legal 8'h01..8'h99.
- `SCALE_LOG2`, 2: font pixel size is 2^SCALE_LOG2 screen pixels (default 4).
- `P1_X`, 256: left edge of P1 tens digit, in screen pixels.
- `P2_X`, 352: left edge of P2 tens digit.
- `DIG_Y`, 16: top edge of all digits.

Ports:
- `clk_pix` in, 1: pixel clock.
- `rst` in, 1: asynchronous, active-high reset.
- `frame` in, 1: one-cycle pulse at the start of vertical blanking (`animate`).
- `clear` in, 1: synchronous score/game reset.
- `miss_l` in, 1: ball passed the left edge; point to P2.
- `miss_r` in, 1: ball passed the right edge; point to P1.
- `sx`, `sy` in, CORDW: current raster position.
- `de` in, 1: display enable.
- `score_draw` out, 1: score pixel lit; 2-cycle latency.
- `score_p1`, `score_p2` out, 8: BCD scores.
- `game_over` out, 1: a player reached WIN_SCORE.
- `winner` out, 1: 0 = P1, 1 = P2; valid while `game_over`.

## Operation
- Reset values: all outputs 0, pending flags 0, pipeline 0.
- Miss capture: `miss_l`/`miss_r` set sticky pending flags on any cycle. Multiple pulses within one frame count as one point.
- Score update on `frame`:
  - P1 += 1 if pending_r; P2 += 1 if pending_l.
  - Pending flags clear on the same edge.
  - A miss arriving on the `frame` cycle itself goes to the next frame.
- BCD increment: ones digit 9 → 0 with carry into tens. 99 saturates (unreachable when WIN_SCORE ≤ 99).
- Game over: evaluated on the post-update values in the same edge.
  - If P1 == WIN_SCORE: `game_over`=1, `winner`=0.
  - Else if P2 == WIN_SCORE: `game_over`=1, `winner`=1. P1 wins ties.
- While `game_over` is set, scores are frozen and misses are ignored; pending flags are held at 0.
- `clear` zeroes scores, pending flags, `game_over` and `winner`. It takes priority over `frame` and misses in the same cycle.
- Rendering uses a 3×5 font, cell width 3 units plus a 1-unit gap.
  - P1 tens cell at P1_X, ones cell at P1_X + 4·2^SCALE_LOG2; same layout for P2.
  - The tens digit is blanked when 0 (leading-zero suppression). The ones digit is always drawn.

## Timing
- Scores, `game_over` and `winner` change only on the edge that samples `frame` or `clear` high.
- Render pipeline, stage 1 (registered):
  - Cell hit, cell id (0–3), column = (sx − cell_x) >> SCALE_LOG2, row = (sy − DIG_Y) >> SCALE_LOG2.
  - `de` delayed by one cycle.
- Render pipeline, stage 2 (registered): `score_draw` = de_d & hit_d & font bit & ~blank. The digit value comes from the current score registers.
- Total latency is 2 cycles from sx/sy/de to `score_draw`. The top delays hsync, vsync and the other draw terms by 2 to match.
- No out-of-range coordinates: subtractions are only used under a hit condition that is evaluated on full CORDW+1-bit compares.

## Configuration
- `PONG_SCORE_BLINK_EN` defined:
  - An internal 5-bit frame counter increments on `frame`.
  - While `game_over`, the winner's digits are drawn only when counter[4]==0 (16 frames on, 16 off). The loser's digits stay steady.
  - The counter resets to 0 on `rst` and on `clear`.
- Undefined: no counter; digits stay steady at game over.

## Structure
- Shared package `pong_pkg`:
  - `score_t` (8-bit BCD) typedef.
  - `FONT_3X5` constant array [0:9] of 15-bit glyphs (row-major, MSB = top-left).
  - Digit/gap unit constants.
- Sub-module `bcd_inc`: 2-digit BCD incrementer with saturate at 99. It is instantiated once per player.

## Test plan
- Reset mid-frame with `rst`=1 → all outputs 0 asynchronously; `score_draw`=0 at P1_X,DIG_Y.
- 3 `miss_r` pulses in one frame, then `frame` → `score_p1`=8'h01, `score_p2`=8'h00.
- Drive P1 from 8'h09 with one miss + `frame` → 8'h10; the tens digit becomes visible at pixel (P1_X+4, DIG_Y) two cycles later.
- WIN_SCORE=8'h03, both players at 8'h02, `miss_l`+`miss_r` then `frame` → both 8'h03, `game_over`=1, `winner`=0. Further misses leave the scores unchanged.
- `clear` and `frame` in the same cycle with pending misses → scores 8'h00, `game_over`=0, no point on the next `frame`.
- Score 8'h07 for P2, raster scan → `score_draw` pattern equals `FONT_3X5[7]` scaled ×4 at P2_X+16, delayed 2 cycles. Gated off when `de`=0.
